// File: rtl/fpmul_bus_master.sv
// Bus initiator for the memory-mapped FP multiplier: writes operands, starts,
// polls status until done (or timeout), reads the product and drops start.
module fpmul_bus_master #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [5:0]  flags,
  output logic        err,
  output logic [1:0]  A,
  output logic        WE,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   LP_GO   = 32'h0001_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_GO,
    S_POLL,
    S_RD_RES,
    S_CLEAR,
    S_FIN
  } state_t;

  state_t        r_state;
  logic [31:0]   r_op_b;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_result;
  logic [5:0]    r_flags;
  logic          r_err;
  logic [1:0]    r_a;
  logic          r_we;
  logic [31:0]   r_wd;

  // Bus outputs are loaded on the transition into a state, so each state's
  // A/WE/WD are valid for the whole cycle spent in it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op_b   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_err    <= 1'b0;
      r_a      <= 2'b00;
      r_we     <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            // op_a goes straight into the first write word; only op_b needs holding
            r_op_b  <= op_b;
            r_busy  <= 1'b1;
            r_state <= S_WR_A;
            r_a     <= 2'b00;
            r_we    <= 1'b1;
            r_wd    <= op_a;
          end
        end
        S_WR_A: begin
          r_state <= S_WR_B;
          r_a     <= 2'b01;
          r_we    <= 1'b1;
          r_wd    <= r_op_b;
        end
        S_WR_B: begin
          r_state <= S_WR_GO;
          r_a     <= 2'b11;
          r_we    <= 1'b1;
          r_wd    <= LP_GO;
        end
        S_WR_GO: begin
          r_state <= S_POLL;
          r_cnt   <= '0;
          r_a     <= 2'b11;
          r_we    <= 1'b0;
          r_wd    <= '0;
        end
        S_POLL: begin
          if (RD[0]) begin
            r_flags <= RD[13:8];
            r_err   <= 1'b0;
            r_state <= S_RD_RES;
            r_a     <= 2'b10;
            r_we    <= 1'b0;
            r_wd    <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_err    <= 1'b1;
            r_result <= '0;
            r_flags  <= '0;
            r_state  <= S_CLEAR;
            r_a      <= 2'b11;
            r_we     <= 1'b1;
            r_wd     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_RES: begin
          r_result <= RD;
          r_state  <= S_CLEAR;
          r_a      <= 2'b11;
          r_we     <= 1'b1;
          r_wd     <= '0;
        end
        S_CLEAR: begin
          r_state <= S_FIN;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_a     <= 2'b00;
          r_we    <= 1'b0;
          r_wd    <= '0;
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_a     <= 2'b00;
          r_we    <= 1'b0;
          r_wd    <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_a     <= 2'b00;
          r_we    <= 1'b0;
          r_wd    <= '0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign flags  = r_flags;
  assign err    = r_err;
  assign A      = r_a;
  assign WE     = r_we;
  assign WD     = r_wd;

endmodule

// File: tb/tb_fpmul_bus_master.sv
// Directed bench for fpmul_bus_master with a small behavioural peripheral
// whose status register reports done after a configurable number of polls.
module tb_fpmul_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, err, WE;
  logic [31:0] result, WD, RD;
  logic [5:0]  flags;
  logic [1:0]  A;

  fpmul_bus_master #(.TIMEOUT(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .flags(flags), .err(err),
    .A(A), .WE(WE), .WD(WD), .RD(RD)
  );

  always #5 clk = ~clk;

  // Peripheral model and bus monitor
  int          poll_target = 1;
  int          stat_base   = 0;
  logic [31:0] status_val  = 32'h0001_0001;
  logic [31:0] prod_val    = '0;
  logic [31:0] reg_a = '0, reg_b = '0;

  int          cyc = 0;
  int          wr_n = 0, n_stat = 0, n_res = 0, n_done = 0;
  logic [1:0]  wr_a [0:255];
  logic [31:0] wr_d [0:255];
  int          done_t [0:255];

  always_comb begin
    RD = '0;
    case (A)
      2'b00: RD = reg_a;
      2'b01: RD = reg_b;
      2'b10: RD = prod_val;
      2'b11: RD = ((n_stat - stat_base) >= poll_target - 1) ? status_val : 32'h0001_0000;
      default: RD = '0;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (WE) begin
      wr_a[wr_n & 255] <= A;
      wr_d[wr_n & 255] <= WD;
      wr_n <= wr_n + 1;
      if (A == 2'b00) reg_a <= WD;
      if (A == 2'b01) reg_b <= WD;
    end
    if (!WE && A == 2'b11) n_stat <= n_stat + 1;
    if (!WE && A == 2'b10) n_res <= n_res + 1;
    if (done) begin
      done_t[n_done & 255] <= cyc;
      n_done <= n_done + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_first);
    @(negedge clk);
    op_a = a; op_b = b; req = 1'b1; stat_base = n_stat;
    @(posedge clk);
    #1;
    req = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'hBAD0_0000;
    lat = 1;
    @(negedge clk);
    busy_first = busy;
    while (!done && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) lat = -1;
    $display("op a=%h b=%h -> result=%h flags=%b err=%b latency=%0d",
             a, b, result, flags, err, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
    n_total++; if (flags !== 6'h0) $display("FAIL reset_flags got %b want 0", flags); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_total++; if (A !== 2'b00) $display("FAIL reset_A got %b want 00", A); else n_pass++;
    n_total++; if (WE !== 1'b0) $display("FAIL reset_WE got %b want 0", WE); else n_pass++;
    n_total++; if (WD !== 32'h0) $display("FAIL reset_WD got %h want 0", WD); else n_pass++;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic();
    int lat; logic bf; int w0, s0, r0;
    poll_target = 4; status_val = 32'h0001_0001; prod_val = 32'h4040_0000;
    w0 = wr_n; s0 = n_stat; r0 = n_res;
    run_op(32'h3FC0_0000, 32'h4000_0000, lat, bf);
    @(posedge clk); #1;
    n_total++; if (lat !== 10) $display("FAIL basic_latency got %0d want 10", lat); else n_pass++;
    n_total++; if (bf !== 1'b1) $display("FAIL basic_busy got %b want 1", bf); else n_pass++;
    n_total++; if (result !== 32'h4040_0000) $display("FAIL basic_result got %h want 40400000", result); else n_pass++;
    n_total++; if (flags !== 6'b0) $display("FAIL basic_flags got %b want 000000", flags); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL basic_err got %b want 0", err); else n_pass++;
    n_total++; if (wr_n - w0 !== 4) $display("FAIL basic_nwrites got %0d want 4", wr_n - w0); else n_pass++;
    n_total++; if (wr_a[w0] !== 2'b00 || wr_d[w0] !== 32'h3FC0_0000)
      $display("FAIL basic_wr0 got %b:%h want 00:3fc00000", wr_a[w0], wr_d[w0]); else n_pass++;
    n_total++; if (wr_a[w0+1] !== 2'b01 || wr_d[w0+1] !== 32'h4000_0000)
      $display("FAIL basic_wr1 got %b:%h want 01:40000000", wr_a[w0+1], wr_d[w0+1]); else n_pass++;
    n_total++; if (wr_a[w0+2] !== 2'b11 || wr_d[w0+2] !== 32'h0001_0000)
      $display("FAIL basic_wr2 got %b:%h want 11:00010000", wr_a[w0+2], wr_d[w0+2]); else n_pass++;
    n_total++; if (wr_a[w0+3] !== 2'b11 || wr_d[w0+3] !== 32'h0)
      $display("FAIL basic_wr3 got %b:%h want 11:00000000", wr_a[w0+3], wr_d[w0+3]); else n_pass++;
    n_total++; if (n_stat - s0 !== 4) $display("FAIL basic_polls got %0d want 4", n_stat - s0); else n_pass++;
    n_total++; if (n_res - r0 !== 1) $display("FAIL basic_resreads got %0d want 1", n_res - r0); else n_pass++;
  endtask

  task automatic test_zero();
    int lat; logic bf;
    poll_target = 1; status_val = 32'h0001_0101; prod_val = 32'h0;
    run_op(32'h0, 32'h4120_0000, lat, bf);
    n_total++; if (lat !== 7) $display("FAIL zero_latency got %0d want 7", lat); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (result !== 32'h0) $display("FAIL zero_result got %h want 0", result); else n_pass++;
    n_total++; if (flags !== 6'b000001) $display("FAIL zero_flags got %b want 000001", flags); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL zero_err got %b want 0", err); else n_pass++;
  endtask

  task automatic test_busy_req();
    int lat; int w0, d0;
    poll_target = 2; status_val = 32'h0001_0101; prod_val = 32'h4040_0000;
    w0 = wr_n; d0 = n_done;
    @(negedge clk);
    op_a = 32'h3F80_0000; op_b = 32'h4040_0000; req = 1'b1; stat_base = n_stat;
    @(posedge clk); #1; req = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      if (done) break;
      req = (lat >= 2 && lat <= 6) ? ~req : 1'b0;
      @(posedge clk); lat++;
    end
    @(negedge clk); req = 1'b0;
    repeat (6) @(negedge clk);
    $display("op a=3f800000 b=40400000 with req pulses while busy -> done count %0d", n_done - d0);
    n_total++; if (n_done - d0 !== 1) $display("FAIL busyreq_dones got %0d want 1", n_done - d0); else n_pass++;
    n_total++; if (wr_n - w0 !== 4) $display("FAIL busyreq_writes got %0d want 4", wr_n - w0); else n_pass++;
    n_total++; if (result !== 32'h4040_0000) $display("FAIL busyreq_result got %h want 40400000", result); else n_pass++;
  endtask

  task automatic test_timeout();
    int lat; logic bf; int w0, s0, r0;
    poll_target = 1000; status_val = 32'h0001_0001; prod_val = 32'h1234_5678;
    w0 = wr_n; s0 = n_stat; r0 = n_res;
    run_op(32'h4000_0000, 32'h4000_0000, lat, bf);
    n_total++; if (lat !== 13) $display("FAIL timeout_latency got %0d want 13", lat); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL timeout_err got %b want 1", err); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL timeout_result got %h want 0", result); else n_pass++;
    n_total++; if (flags !== 6'b0) $display("FAIL timeout_flags got %b want 000000", flags); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (n_stat - s0 !== 8) $display("FAIL timeout_polls got %0d want 8", n_stat - s0); else n_pass++;
    n_total++; if (n_res - r0 !== 0) $display("FAIL timeout_resreads got %0d want 0", n_res - r0); else n_pass++;
    n_total++; if (wr_n - w0 !== 4) $display("FAIL timeout_writes got %0d want 4", wr_n - w0); else n_pass++;
    n_total++; if (wr_a[w0+3] !== 2'b11 || wr_d[w0+3] !== 32'h0)
      $display("FAIL timeout_clear got %b:%h want 11:00000000", wr_a[w0+3], wr_d[w0+3]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic bf; int w0, d0;
    poll_target = 1000;
    w0 = wr_n; d0 = n_done;
    @(negedge clk);
    op_a = 32'h3F80_0000; op_b = 32'h3F80_0000; req = 1'b1; stat_base = n_stat;
    @(posedge clk); #1; req = 1'b0;
    repeat (4) @(posedge clk);   // now in the 2nd POLL cycle
    @(negedge clk);
    n_total++; if (!(A === 2'b11 && WE === 1'b0)) $display("FAIL midrst_inpoll got A=%b WE=%b want 11/0", A, WE); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_total++; if (WE !== 1'b0) $display("FAIL midrst_WE got %b want 0", WE); else n_pass++;
    n_total++; if (A !== 2'b00) $display("FAIL midrst_A got %b want 00", A); else n_pass++;
    repeat (15) @(negedge clk);
    $display("reset during poll -> dones %0d writes %0d", n_done - d0, wr_n - w0);
    n_total++; if (n_done - d0 !== 0) $display("FAIL midrst_nodone got %0d want 0", n_done - d0); else n_pass++;
    n_total++; if (wr_n - w0 !== 3) $display("FAIL midrst_noclear got %0d want 3", wr_n - w0); else n_pass++;
    poll_target = 2; status_val = 32'h0001_0001; prod_val = 32'h3F80_0000;
    run_op(32'h3F80_0000, 32'h3F80_0000, lat, bf);
    n_total++; if (lat !== 8) $display("FAIL midrst_fresh_latency got %0d want 8", lat); else n_pass++;
    n_total++; if (result !== 32'h3F80_0000) $display("FAIL midrst_fresh_result got %h want 3f800000", result); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, k;
    poll_target = 1; status_val = 32'h0001_0001; prod_val = 32'h4080_0000;
    d0 = n_done;
    @(negedge clk);
    op_a = 32'h4000_0000; op_b = 32'h4000_0000; req = 1'b1; stat_base = n_stat;
    k = 0;
    while (n_done - d0 < 3 && k < 200) begin
      @(negedge clk); k++;
    end
    req = 1'b0;
    if (n_done - d0 < 3) begin
      n_total++; $display("FAIL b2b_timeout got %0d dones want 3", n_done - d0);
    end else begin
      $display("back-to-back done cycles %0d %0d %0d", done_t[d0], done_t[d0+1], done_t[d0+2]);
      n_total++; if (done_t[d0+1] - done_t[d0] !== 8)
        $display("FAIL b2b_gap1 got %0d want 8", done_t[d0+1] - done_t[d0]); else n_pass++;
      n_total++; if (done_t[d0+2] - done_t[d0+1] !== 8)
        $display("FAIL b2b_gap2 got %0d want 8", done_t[d0+2] - done_t[d0+1]); else n_pass++;
    end
    repeat (12) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_busy_req();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fpmul_bus_master.md
Name: fpmul_bus_master

Overview:
Hardware initiator that drives the memory-mapped FP multiplier peripheral over its 2-bit-address register bus, replacing software polling.
- On a request it writes operand A (addr 0), operand B (addr 1) and the start bit (addr 3, bit 16).
- It then polls status (addr 3, bit 0) until done, reads the product (addr 2), and clears the start bit.
- It sits between a datapath client (req/ack style) and the peripheral's A/WE/InData/OutData port.

Parameters:
TIMEOUT, 255, maximum POLL cycles before abandoning the operation (must be ≥1).
CW, 8, width of poll counter; must satisfy 2^CW > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req  in  1  start a multiply; sampled only in IDLE
op_a  in  32  IEEE-754 single operand A, latched on accepted req
op_b  in  32  IEEE-754 single operand B, latched on accepted req
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse, result/flags/err valid from this cycle until next acceptance
result  out  32  product read from addr 2
flags  out  6  {OF,UF,NAN,INF,DN,Z} from status bits [13:8]
err  out  1  timeout indicator, valid with done
A  out  2  peripheral register address
WE  out  1  peripheral write enable
WD  out  32  peripheral write data
RD  in  32  peripheral read data (combinational from A, same cycle)

Behaviour:
- Reset: state IDLE, busy=0, done=0, result=0, flags=0, err=0, A=2'b00, WE=0, WD=0, poll counter=0. Reset mid-transaction aborts immediately; no clear write is issued.
- Bus outputs are registered per state and are a function of state only. In all non-write states WE=0 and WD=0.
- IDLE: A=00. If req=1, latch op_a/op_b → WR_A. busy=1 from WR_A onward.
- WR_A: A=00, WE=1, WD=op_a → WR_B.
- WR_B: A=01, WE=1, WD=op_b → WR_GO.
- WR_GO: A=11, WE=1, WD=32'h0001_0000 → POLL, counter=0. This write clears the peripheral's done flag.
- POLL: A=11, WE=0; RD is sampled this cycle.
  - RD[0]=1: flags<=RD[13:8], err<=0 → RD_RES.
  - RD[0]=0 and counter==TIMEOUT-1: err<=1, result<=0, flags<=0 → CLEAR.
  - Otherwise counter++.
- RD_RES: A=10, result<=RD → CLEAR.
- CLEAR: A=11, WE=1, WD=0 (drops the start bit; done flag is unaffected) → FIN.
- FIN: done=1, busy=0, A=00 → IDLE.
- Latency, accepted req to done: 6 + N cycles, where N = POLL cycles (≥1). Timeout case: N = TIMEOUT, no RD_RES cycle.
- req is ignored while busy and during FIN. If req is held high through FIN, the next operation is accepted in the IDLE cycle that follows; there is no back-to-back acceptance in FIN.
- op_a/op_b changes after acceptance have no effect.
- result, flags and err hold their values until the next POLL/RD_RES update.

Test Plan:
- op_a=32'h3FC0_0000, op_b=32'h4000_0000, peripheral model asserts done after 4 polls → bus trace writes 00:3FC00000, 01:40000000, 11:00010000; 4 status reads; read at 10; write 11:00000000. Then done pulse with result=32'h4040_0000, flags=0, err=0, latency 10 cycles.
- op_a=0, op_b=32'h4120_0000, model returns status 32'h0001_0101 → result=0, flags=6'b000001, err=0.
- Second req pulses during busy → no extra bus writes; exactly one done.
- TIMEOUT=8, model never sets bit 0 → exactly 8 POLL reads, clear write 11:0, done with err=1, result=0, no addr-10 read.
- rst asserted during the 2nd POLL cycle → next cycle busy=0, WE=0, A=00, no done pulse; a fresh req afterwards completes normally.
- req held high continuously → transactions repeat, one idle cycle between done and the next WR_A, done pulses spaced 6+N+1 cycles apart.
